// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the pipelined FFT output-reorder stage:
//   - MAXLOG2N        : largest supported log2 transform length
//   - NB_DEFAULT      : default core input width
//   - data_width(nb)  : stored/forwarded sample width, nb+3
//   - bitrev()        : radix-2 bit reversal of the low log2n bits
//   - digitrev4()     : radix-4 digit reversal of the low log2n bits
//   - wstate_e/rstate_e : write-side and read-side FSM states
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int MAXLOG2N   = 12;
  localparam int NB_DEFAULT = 16;

  typedef enum logic {
    WIDLE = 1'b0,
    WFILL = 1'b1
  } wstate_e;

  typedef enum logic {
    RIDLE = 1'b0,
    RRUN  = 1'b1
  } rstate_e;

  // The core grows its data by three bits over its internal stages.
  function automatic int data_width(input int nb);
    return nb + 3;
  endfunction

  // Reverse the whole MAXLOG2N-bit word, then shift the reversed low field
  // back down so only the low log2n bits participate.
  function automatic logic [MAXLOG2N-1:0] bitrev(input logic [MAXLOG2N-1:0] x,
                                                 input int                  log2n);
    logic [MAXLOG2N-1:0] r;
    r = {<<{x}};
    return r >> (MAXLOG2N - log2n);
  endfunction

  // Same idea with 2-bit slices; log2n must be even for a clean digit split.
  function automatic logic [MAXLOG2N-1:0] digitrev4(input logic [MAXLOG2N-1:0] x,
                                                    input int                  log2n);
    logic [MAXLOG2N-1:0] r;
    r = {<<2{x}};
    return r >> (MAXLOG2N - log2n);
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// ---------------------------------------------------------------------------
// fft_pingpong_ram
// Simple dual-port RAM holding two frame banks. Address is {bank, index}.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address {bank, index}
//   wdata_i  in   write data {re, im}
//   re_i     in   read enable; rdata_o only changes when re_i is high
//   raddr_i  in   read address {bank, index}
//   rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module fft_pingpong_ram #(
  parameter int AW = 7,
  parameter int WW = 38
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);

  logic [WW-1:0] mem_q [0:(1<<AW)-1];

  // No reset on the storage or the read register so this maps onto block RAM.
  // Holding rdata_o when re_i is low is what lets the output stall for free.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/pipelined_fft_reorder.sv
// ---------------------------------------------------------------------------
// pipelined_fft_reorder
// Captures a pipelined FFT core's digit-reversed result stream into a
// ping-pong RAM and replays every frame in natural bin order on a
// valid/ready stream, tagged with the frame's accumulated overflow flags.
//   CLK     in   clock
//   RST     in   asynchronous active-low reset
//   ED      in   write-side enable (core ED)
//   RDY     in   core RDY; result 0 arrives on the next ED cycle
//   DIR/DII in   core real/imag result
//   OVF1/2  in   core stage overflow flags
//   CLR     in   synchronous clear of the sticky error flags
//   OVALID  out  output sample valid
//   OREADY  in   downstream accepts the sample
//   OADDR   out  natural bin index
//   DOR/DOI out  real/imag sample
//   OLAST   out  high with bin N-1
//   FOVF    out  {OVF2,OVF1} OR-ed over the frame being output
//   ERR_OVR out  sticky: frame dropped because both banks were full
//   ERR_SYN out  sticky: RDY arrived mid-frame
// ---------------------------------------------------------------------------
module pipelined_fft_reorder
  import fft_pkg::*;
#(
  parameter  int LOG2N    = 6,
  parameter  int NB       = NB_DEFAULT,
  parameter  int REV_MODE = 1,
  localparam int DW       = data_width(NB)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ED,
  input  logic             RDY,
  input  logic [DW-1:0]    DIR,
  input  logic [DW-1:0]    DII,
  input  logic             OVF1,
  input  logic             OVF2,
  input  logic             CLR,
  output logic             OVALID,
  input  logic             OREADY,
  output logic [LOG2N-1:0] OADDR,
  output logic [DW-1:0]    DOR,
  output logic [DW-1:0]    DOI,
  output logic             OLAST,
  output logic [1:0]       FOVF,
  output logic             ERR_OVR,
  output logic             ERR_SYN
);

  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  // Write side state
  wstate_e          wstate_q, wstate_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       ovf_acc_q, ovf_acc_d;
  logic             drop_q, drop_d;

  // Read side state
  rstate_e          rstate_q, rstate_d;
  logic             rbank_q, rbank_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rdone_q, rdone_d;
  logic             ovalid_q, ovalid_d;
  logic [LOG2N-1:0] oaddr_q, oaddr_d;
  logic             olast_q, olast_d;
  logic [1:0]       fovf_q, fovf_d;

  // Per-bank bookkeeping
  logic [1:0]       full_q, full_d;
  logic [1:0]       tag_q [2];
  logic [1:0]       tag_d [2];
  logic [1:0]       bank_busy;
  logic [1:0]       set_full;
  logic [1:0]       wtag;

  logic             err_ovr_q, err_ovr_d;
  logic             err_syn_q, err_syn_d;
  logic             set_ovr, set_syn;

  // Internal handshakes
  logic             free_en;
  logic             nxt_bank;
  logic             issue;
  logic             issue_bank;
  logic [LOG2N-1:0] issue_idx;
  logic             hs, adv;
  logic [LOG2N-1:0] rev_idx;

  logic                    ram_we;
  logic [LOG2N:0]          ram_waddr;
  logic [2*DW-1:0]         ram_wdata;
  logic [2*DW-1:0]         ram_rdata;

  // Physical slot for the current write index.
  always_comb begin
    case (REV_MODE)
      0:       rev_idx = LOG2N'(bitrev(MAXLOG2N'(wcnt_q), LOG2N));
      1:       rev_idx = LOG2N'(digitrev4(MAXLOG2N'(wcnt_q), LOG2N));
      default: rev_idx = wcnt_q;
    endcase
  end

  // A bank counts as busy unless the reader releases it in this very cycle,
  // so a frame starting on the handover cycle is not dropped needlessly.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_busy[gi] = full_q[gi] & ~(free_en & (rbank_q == 1'(gi)));
    assign full_d[gi]    = set_full[gi] | bank_busy[gi];
    assign tag_d[gi]     = set_full[gi] ? wtag : tag_q[gi];
  end

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    wstate_d  = wstate_q;
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    ovf_acc_d = ovf_acc_q;
    drop_d    = drop_q;
    nxt_bank  = wbank_q;
    set_full  = '0;
    set_ovr   = 1'b0;
    set_syn   = 1'b0;
    wtag      = ovf_acc_q | {OVF2, OVF1};
    ram_we    = 1'b0;
    ram_waddr = {wbank_q, rev_idx};
    ram_wdata = {DIR, DII};
    case (wstate_q)
      WIDLE: begin
        if (ED && RDY) begin
          wstate_d  = WFILL;
          wcnt_d    = '0;
          ovf_acc_d = '0;
          drop_d    = bank_busy[wbank_q];
          set_ovr   = bank_busy[wbank_q];
        end
      end
      WFILL: begin
        if (ED) begin
          if (RDY && (wcnt_q != LAST_IDX)) begin
            // Resync: restart the frame in the same bank, discarding partials.
            wcnt_d    = '0;
            ovf_acc_d = '0;
            set_syn   = 1'b1;
            drop_d    = bank_busy[wbank_q];
            set_ovr   = bank_busy[wbank_q];
          end else begin
            // A dropped frame still counts samples so the next RDY lines up.
            ram_we    = ~drop_q;
            ovf_acc_d = wtag;
            wcnt_d    = wcnt_q + 1'b1;
            if (wcnt_q == LAST_IDX) begin
              if (!drop_q) begin
                set_full[wbank_q] = 1'b1;
                nxt_bank          = ~wbank_q;
              end
              wbank_d = nxt_bank;
              if (RDY) begin
                ovf_acc_d = '0;
                drop_d    = bank_busy[nxt_bank];
                set_ovr   = bank_busy[nxt_bank];
              end else begin
                wstate_d = WIDLE;
              end
            end
          end
        end
      end
      default: wstate_d = WIDLE;
    endcase
  end

  // ----------------------------------------------------------------- read FSM
  // One prefetch stage: the RAM read register is the output data register, so
  // a stall simply withholds the read enable and the sample stays put.
  always_comb begin
    rstate_d   = rstate_q;
    rbank_d    = rbank_q;
    rcnt_d     = rcnt_q;
    rdone_d    = rdone_q;
    ovalid_d   = ovalid_q;
    oaddr_d    = oaddr_q;
    olast_d    = olast_q;
    fovf_d     = fovf_q;
    free_en    = 1'b0;
    issue      = 1'b0;
    issue_bank = rbank_q;
    issue_idx  = rcnt_q;
    hs         = ovalid_q & OREADY;
    adv        = ~ovalid_q | OREADY;
    case (rstate_q)
      RIDLE: begin
        if (full_q[rbank_q]) begin
          rstate_d = RRUN;
          rcnt_d   = '0;
          rdone_d  = 1'b0;
        end
      end
      RRUN: begin
        if (hs && olast_q) begin
          free_en = 1'b1;
          rbank_d = ~rbank_q;
          // Chain straight into the other bank to avoid a bubble.
          if (full_q[~rbank_q]) begin
            issue      = 1'b1;
            issue_bank = ~rbank_q;
            issue_idx  = '0;
          end else begin
            rstate_d = RIDLE;
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
          end
        end else if (adv) begin
          if (!rdone_q) begin
            issue = 1'b1;
          end else begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
          end
        end
      end
      default: rstate_d = RIDLE;
    endcase
    if (issue) begin
      ovalid_d = 1'b1;
      oaddr_d  = issue_idx;
      olast_d  = (issue_idx == LAST_IDX);
      rcnt_d   = issue_idx + 1'b1;
      rdone_d  = (issue_idx == LAST_IDX);
      fovf_d   = tag_q[issue_bank];
    end
  end

  // Error events take precedence over a coincident clear.
  assign err_ovr_d = set_ovr | (err_ovr_q & ~CLR);
  assign err_syn_d = set_syn | (err_syn_q & ~CLR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wstate_q  <= WIDLE;
      wcnt_q    <= '0;
      wbank_q   <= 1'b0;
      ovf_acc_q <= '0;
      drop_q    <= 1'b0;
      rstate_q  <= RIDLE;
      rbank_q   <= 1'b0;
      rcnt_q    <= '0;
      rdone_q   <= 1'b0;
      ovalid_q  <= 1'b0;
      oaddr_q   <= '0;
      olast_q   <= 1'b0;
      fovf_q    <= '0;
      full_q    <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      err_ovr_q <= 1'b0;
      err_syn_q <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      wcnt_q    <= wcnt_d;
      wbank_q   <= wbank_d;
      ovf_acc_q <= ovf_acc_d;
      drop_q    <= drop_d;
      rstate_q  <= rstate_d;
      rbank_q   <= rbank_d;
      rcnt_q    <= rcnt_d;
      rdone_q   <= rdone_d;
      ovalid_q  <= ovalid_d;
      oaddr_q   <= oaddr_d;
      olast_q   <= olast_d;
      fovf_q    <= fovf_d;
      full_q    <= full_d;
      tag_q[0]  <= tag_d[0];
      tag_q[1]  <= tag_d[1];
      err_ovr_q <= err_ovr_d;
      err_syn_q <= err_syn_d;
    end
  end

  fft_pingpong_ram #(
    .AW (LOG2N + 1),
    .WW (2 * DW)
  ) u_ram (
    .clk     (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (issue),
    .raddr_i ({issue_bank, issue_idx}),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is unreset, so data is masked while nothing is valid.
  assign OVALID  = ovalid_q;
  assign OADDR   = oaddr_q;
  assign OLAST   = olast_q;
  assign FOVF    = fovf_q;
  assign DOR     = ovalid_q ? ram_rdata[2*DW-1:DW] : '0;
  assign DOI     = ovalid_q ? ram_rdata[DW-1:0]    : '0;
  assign ERR_OVR = err_ovr_q;
  assign ERR_SYN = err_syn_q;

endmodule

// File: tb/tb_pipelined_fft_reorder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_fft_reorder
// Directed bench for pipelined_fft_reorder with LOG2N=6, NB=16, REV_MODE=1.
// Frames carry x[k] = base + k fed in digit-reversed order, so natural bin a
// must come out as base + a on DOR and 0x40000 | (base + a) on DOI.
// ---------------------------------------------------------------------------
module tb_pipelined_fft_reorder;

  localparam int LOG2N = 6;
  localparam int N     = 64;
  localparam int NB    = 16;
  localparam int DW    = 19;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             ED = 1'b0;
  logic             RDY = 1'b0;
  logic [DW-1:0]    DIR = '0;
  logic [DW-1:0]    DII = '0;
  logic             OVF1 = 1'b0;
  logic             OVF2 = 1'b0;
  logic             CLR = 1'b0;
  logic             OREADY = 1'b0;
  logic             OVALID;
  logic [LOG2N-1:0] OADDR;
  logic [DW-1:0]    DOR;
  logic [DW-1:0]    DOI;
  logic             OLAST;
  logic [1:0]       FOVF;
  logic             ERR_OVR;
  logic             ERR_SYN;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q_addr[$];
  int q_dor[$];
  int q_doi[$];
  int q_last[$];
  int q_fovf[$];
  int q_cyc[$];

  pipelined_fft_reorder #(
    .LOG2N    (LOG2N),
    .NB       (NB),
    .REV_MODE (1)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ED      (ED),
    .RDY     (RDY),
    .DIR     (DIR),
    .DII     (DII),
    .OVF1    (OVF1),
    .OVF2    (OVF2),
    .CLR     (CLR),
    .OVALID  (OVALID),
    .OREADY  (OREADY),
    .OADDR   (OADDR),
    .DOR     (DOR),
    .DOI     (DOI),
    .OLAST   (OLAST),
    .FOVF    (FOVF),
    .ERR_OVR (ERR_OVR),
    .ERR_SYN (ERR_SYN)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Handshakes are recorded mid-cycle; they complete on the following edge.
  always @(negedge CLK) begin
    if (RST && OVALID && OREADY) begin
      q_addr.push_back(int'(OADDR));
      q_dor.push_back(int'(DOR));
      q_doi.push_back(int'(DOI));
      q_last.push_back(int'(OLAST));
      q_fovf.push_back(int'(FOVF));
      q_cyc.push_back(cyc);
      $display("out cyc=%0d addr=%0d dor=%0h doi=%0h last=%0b fovf=%0b",
               cyc, OADDR, DOR, DOI, OLAST, FOVF);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent 6-bit radix-4 digit reversal.
  function automatic int drev(input int k);
    return ((k & 3) << 4) | (k & 12) | ((k >> 4) & 3);
  endfunction

  task automatic clear_q();
    q_addr.delete(); q_dor.delete(); q_doi.delete();
    q_last.delete(); q_fovf.delete(); q_cyc.delete();
  endtask

  // Optional RDY cycle, then N ED cycles; chain_next raises RDY on the last one.
  task automatic feed(input int base, input int ovf_at, input bit skip_start, input bit chain_next);
    if (!skip_start) begin
      @(posedge CLK); #1;
      ED = 1'b1; RDY = 1'b1; DIR = '0; DII = '0;
    end
    for (int k = 0; k < N; k++) begin
      @(posedge CLK); #1;
      ED   = 1'b1;
      RDY  = chain_next && (k == N - 1);
      DIR  = DW'(base + drev(k));
      DII  = DW'(32'h40000 | (base + drev(k)));
      OVF1 = (k == ovf_at);
    end
    if (!chain_next) begin
      @(posedge CLK); #1;
      ED = 1'b0; RDY = 1'b0; OVF1 = 1'b0;
    end
  endtask

  // Start a frame, send cnt samples, then present RDY again mid-frame.
  task automatic feed_partial(input int base, input int cnt);
    @(posedge CLK); #1;
    ED = 1'b1; RDY = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      @(posedge CLK); #1;
      RDY = 1'b0;
      DIR = DW'(base + drev(k));
      DII = DW'(32'h40000 | (base + drev(k)));
    end
    @(posedge CLK); #1;
    RDY = 1'b1;
  endtask

  task automatic wait_samples(input string tag, input int n, input int budget);
    int k = 0;
    while (q_addr.size() < n && k < budget) begin
      @(posedge CLK);
      k++;
    end
    #1;
    chk(tag, q_addr.size(), n);
  endtask

  task automatic check_frame(input string tag, input int off, input int base, input int fovf);
    for (int i = 0; i < N; i++) begin
      if (off + i < q_addr.size()) begin
        chk({tag, "_addr"}, q_addr[off+i], i);
        chk({tag, "_dor"},  q_dor[off+i],  base + i);
        chk({tag, "_doi"},  q_doi[off+i],  32'h40000 | (base + i));
        chk({tag, "_last"}, q_last[off+i], (i == N - 1) ? 1 : 0);
        chk({tag, "_fovf"}, q_fovf[off+i], fovf);
      end
    end
  endtask

  initial begin
    int  k;
    bit  seen;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ovalid", OVALID, 0);
    chk("rst_olast", OLAST, 0);
    chk("rst_oaddr", OADDR, 0);
    chk("rst_dor", DOR, 0);
    chk("rst_fovf", FOVF, 0);
    chk("rst_ovr", ERR_OVR, 0);
    chk("rst_syn", ERR_SYN, 0);
    RST = 1'b1;
    OREADY = 1'b1;

    // 1: single frame, natural order, latency
    feed(0, -1, 1'b0, 1'b0);
    chk("t1_lat0", OVALID, 0);
    @(posedge CLK); #1;
    chk("t1_lat1", OVALID, 0);
    @(posedge CLK); #1;
    chk("t1_lat2", OVALID, 1);
    wait_samples("t1_cnt", N, 200);
    check_frame("t1", 0, 0, 0);
    repeat (10) @(posedge CLK);
    chk("t1_extra", q_addr.size(), N);
    clear_q();

    // 2: back-to-back frames, no gap
    feed(100, -1, 1'b0, 1'b1);
    feed(200, -1, 1'b1, 1'b0);
    wait_samples("t2_cnt", 2 * N, 400);
    check_frame("t2a", 0, 100, 0);
    check_frame("t2b", N, 200, 0);
    if (q_cyc.size() >= 2 * N) chk("t2_gap", q_cyc[2*N-1] - q_cyc[0], 2 * N - 1);
    chk("t2_ovr", ERR_OVR, 0);
    clear_q();

    // 3: stall on bin 17
    feed(300, -1, 1'b0, 1'b0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      @(posedge CLK); #1;
      k++;
      if (OVALID && OADDR == 17) seen = 1'b1;
    end
    chk("t3_seen", seen, 1);
    OREADY = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
    end
    chk("t3_hold_vld", OVALID, 1);
    chk("t3_hold_addr", OADDR, 17);
    chk("t3_hold_dor", DOR, 317);
    chk("t3_stall_cnt", q_addr.size(), 17);
    OREADY = 1'b1;
    wait_samples("t3_cnt", N, 300);
    check_frame("t3", 0, 300, 0);
    clear_q();

    // 4: overrun with OREADY low for three frames
    OREADY = 1'b0;
    feed(400, -1, 1'b0, 1'b0);
    feed(500, -1, 1'b0, 1'b0);
    chk("t4_ovr_pre", ERR_OVR, 0);
    feed(600, -1, 1'b0, 1'b0);
    chk("t4_ovr", ERR_OVR, 1);
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    chk("t4_clr", ERR_OVR, 0);
    OREADY = 1'b1;
    wait_samples("t4_cnt", 2 * N, 400);
    check_frame("t4a", 0, 400, 0);
    check_frame("t4b", N, 500, 0);
    repeat (100) @(posedge CLK);
    #1;
    chk("t4_drop", q_addr.size(), 2 * N);
    clear_q();

    // 5: RDY reasserted at wcnt=20
    chk("t5_syn_pre", ERR_SYN, 0);
    feed_partial(700, 20);
    feed(800, -1, 1'b1, 1'b0);
    chk("t5_syn", ERR_SYN, 1);
    wait_samples("t5_cnt", N, 300);
    check_frame("t5", 0, 800, 0);
    repeat (100) @(posedge CLK);
    #1;
    chk("t5_extra", q_addr.size(), N);
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    chk("t5_clr", ERR_SYN, 0);
    clear_q();

    // 6: overflow tag per frame, then reset mid-output
    feed(900, 5, 1'b0, 1'b1);
    feed(1000, -1, 1'b1, 1'b0);
    wait_samples("t6_cnt", 2 * N, 400);
    check_frame("t6a", 0, 900, 1);
    check_frame("t6b", N, 1000, 0);
    clear_q();
    feed(1100, -1, 1'b0, 1'b0);
    k = 0;
    while (!OVALID && k < 50) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("t6_vld_before_rst", OVALID, 1);
    repeat (5) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_rst_vld", OVALID, 0);
    chk("t6_rst_last", OLAST, 0);
    chk("t6_rst_dor", DOR, 0);
    chk("t6_rst_fovf", FOVF, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("t6_post_vld", OVALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
